// File: rtl/lisnoc_pkg.sv
// Shared definitions for the lisnoc router input stage: flit types, routing
// modes and the routing FSM encoding.
package lisnoc_pkg;

  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  localparam int unsigned ROUTE_SRC = 0;
  localparam int unsigned ROUTE_LUT = 1;

  localparam int unsigned FLIT_DATA_WIDTH = 32;
  localparam int unsigned FLIT_TYPE_WIDTH = 2;

  // Flit in the default configuration: type bits sit above the payload.
  typedef struct packed {
    logic [FLIT_TYPE_WIDTH-1:0] ftype;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    StIdle,
    StRoute,
    StDrop
  } route_state_e;

endpackage

// File: rtl/lisnoc_route_decode.sv
// Combinational header decode: turns a header flit into a one-hot switch
// request plus the flit to forward, for either source or table routing.
module lisnoc_route_decode
  import lisnoc_pkg::*;
#(
  parameter int unsigned FlitDataWidth = 32,
  parameter int unsigned FlitTypeWidth = 2,
  parameter int unsigned Directions    = 5,
  parameter int unsigned HopWidth      = 3,
  parameter int unsigned TidWidth      = 4,
  parameter int unsigned RoutingMode   = ROUTE_SRC,
  parameter int unsigned DestWidth     = 5,
  parameter int unsigned NumDests      = 32,
  parameter logic [NumDests*Directions-1:0] Lookup = '0,
  localparam int unsigned FlitWidth    = FlitDataWidth + FlitTypeWidth
) (
  input  logic [FlitWidth-1:0]  flit_i,
  output logic [Directions-1:0] req_o,
  output logic [FlitWidth-1:0]  flit_o,
  output logic                  valid_o
);

  localparam int unsigned LowWidth = FlitDataWidth - TidWidth;

  logic [HopWidth-1:0]  hop;
  logic [DestWidth-1:0] dest;
  int unsigned          idx;

  assign hop  = flit_i[HopWidth-1:0];
  assign dest = flit_i[LowWidth-1 -: DestWidth];

  always_comb begin
    req_o   = '0;
    flit_o  = flit_i;
    valid_o = 1'b0;
    idx     = 0;
    if (RoutingMode == ROUTE_SRC) begin
      if (32'(hop) < Directions) begin
        valid_o = 1'b1;
        req_o   = Directions'(1) << hop;
      end
      // Consume this hop so the next router sees its own index in the LSBs.
      flit_o[LowWidth-1:0] = flit_i[LowWidth-1:0] >> HopWidth;
    end else begin
      if (32'(dest) < NumDests) begin
        // Entry 0 occupies the most significant slice of the table.
        idx     = (NumDests - 1 - 32'(dest)) * Directions;
        req_o   = Lookup[idx +: Directions];
        valid_o = |req_o;
      end
    end
  end

endmodule

// File: rtl/lisnoc_router_input_route_sr.sv
// Routing stage of a router input port: routes headers, holds the one-hot
// request for the packet and drops malformed or orphaned traffic.
module lisnoc_router_input_route_sr
  import lisnoc_pkg::*;
#(
  parameter int unsigned FlitDataWidth = 32,
  parameter int unsigned FlitTypeWidth = 2,
  parameter int unsigned Directions    = 5,
  parameter int unsigned HopWidth      = 3,
  parameter int unsigned TidWidth      = 4,
  parameter int unsigned RoutingMode   = ROUTE_SRC,
  parameter int unsigned DestWidth     = 5,
  parameter int unsigned NumDests      = 32,
  parameter logic [NumDests*Directions-1:0] Lookup = '0,
  parameter int unsigned CntWidth      = 8,
  localparam int unsigned FlitWidth    = FlitDataWidth + FlitTypeWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [FlitWidth-1:0]  fifo_flit_i,
  input  logic                  fifo_valid_i,
  output logic                  fifo_ready_o,
  output logic [Directions-1:0] switch_request_o,
  output logic [FlitWidth-1:0]  switch_flit_o,
  input  logic [Directions-1:0] switch_read_i,
  output logic [TidWidth-1:0]   traffic_id_o,
  output logic                  route_err_o,
  output logic [CntWidth-1:0]   drop_count_o
);

  route_state_e          state_q, state_d;
  logic [Directions-1:0] req_q, req_d, route_q, route_d;
  logic [FlitWidth-1:0]  flit_q, flit_d;
  logic [TidWidth-1:0]   tid_q, tid_d;
  logic                  err_q, err_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic [Directions-1:0] dec_req;
  logic [FlitWidth-1:0]  dec_flit;
  logic                  dec_valid;
  logic [1:0]            ftype;
  logic                  is_head, is_last, read, drop_evt;

  lisnoc_route_decode #(
    .FlitDataWidth(FlitDataWidth),
    .FlitTypeWidth(FlitTypeWidth),
    .Directions   (Directions),
    .HopWidth     (HopWidth),
    .TidWidth     (TidWidth),
    .RoutingMode  (RoutingMode),
    .DestWidth    (DestWidth),
    .NumDests     (NumDests),
    .Lookup       (Lookup)
  ) u_decode (
    .flit_i (fifo_flit_i),
    .req_o  (dec_req),
    .flit_o (dec_flit),
    .valid_o(dec_valid)
  );

  assign ftype   = fifo_flit_i[FlitWidth-1 -: 2];
  assign is_head = (ftype == FLIT_HEADER) || (ftype == FLIT_SINGLE);
  assign is_last = (ftype == FLIT_LAST);
  assign read    = |(switch_read_i & req_q);

  assign fifo_ready_o = fifo_valid_i & ((state_q == StDrop) | ~(|req_q) | read);

  always_comb begin
    state_d  = state_q;
    req_d    = read ? '0 : req_q;
    route_d  = route_q;
    flit_d   = flit_q;
    tid_d    = tid_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    drop_evt = 1'b0;
    if (fifo_ready_o) begin
      case (state_q)
        StIdle: begin
          if (is_head && dec_valid) begin
            req_d   = dec_req;
            route_d = dec_req;
            flit_d  = dec_flit;
            tid_d   = fifo_flit_i[FlitDataWidth-1 -: TidWidth];
            state_d = (ftype == FLIT_HEADER) ? StRoute : StIdle;
          end else begin
            // Bad route or orphan body flit: consume it without a request.
            drop_evt = 1'b1;
            if (ftype == FLIT_HEADER) state_d = StDrop;
          end
        end
        StRoute: begin
          req_d  = route_q;
          flit_d = fifo_flit_i;
          if (is_last) state_d = StIdle;
        end
        StDrop: begin
          if (is_last) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    if (drop_evt) begin
      err_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= '0;
      route_q <= '0;
      flit_q  <= '0;
      tid_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      route_q <= route_d;
      flit_q  <= flit_d;
      tid_q   <= tid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign switch_request_o = req_q;
  assign switch_flit_o    = flit_q;
  assign traffic_id_o     = tid_q;
  assign route_err_o      = err_q;
  assign drop_count_o     = cnt_q;

endmodule

// File: doc/lisnoc_router_input_route_sr.md
Name: lisnoc_router_input_route_sr

Overview:
- Parametrised routing stage of a router input port. Sits between the input FIFO and the switch allocator.
- Supports two routing modes:
  - source routing: per-hop output index carried in the header, consumed hop by hop;
  - table lookup: destination field mapped to a direction.
- Converts the route to a one-hot switch request and holds it for the whole packet.
- Captures the traffic id, and drops malformed packets with an error indication instead of issuing undefined requests.

Parameters:
- flit_data_width, 32, payload bits per flit
- flit_type_width, 2, type bits; flit width = data + type
- directions, 5, number of output ports (one-hot request width)
- hop_width, 3, bits per encoded hop index in source mode
- tid_width, 4, traffic id width, taken from the header MSBs
- routing_mode, 0, 0 = source routed, 1 = table lookup
- dest_width, 5, destination field width in lookup mode
- num_dests, 32, table entries; must be ≤ 2**dest_width
- lookup, all zeros, {dest0_dir, dest1_dir, ...}, each directions bits one-hot
- cnt_width, 8, drop counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- fifo_flit  in  flit_width  FIFO head flit
- fifo_valid  in  1  head flit valid
- fifo_ready  out  1  head flit consumed this cycle
- switch_request  out  directions  one-hot output request
- switch_flit  out  flit_width  flit presented to switch
- switch_read  in  directions  grant/accept per direction
- traffic_id  out  tid_width  traffic id of current packet
- route_err  out  1  one-cycle pulse on drop start
- drop_count  out  cnt_width  saturating count of dropped packets

Behaviour:
- Flit types:
  - HEADER = 01, PAYLOAD = 00, LAST = 10, SINGLE = 11.
  - A packet is HEADER, payload*, LAST; or a single SINGLE flit.
- Reset (rst low, async): switch_request = 0, switch_flit = 0, traffic_id = 0, route_err = 0, drop_count = 0, state IDLE, output register empty. Reset mid-packet clears everything; the rest of that packet later arrives in IDLE and is handled as orphan.
- Output register: single entry (out_valid).
  - out_valid = |switch_request.
  - read = |(switch_read & switch_request); switch_read bits outside the request are ignored.
- Accept rule: fifo_ready = fifo_valid & (state == DROP | ~out_valid | read). Accept and read in the same cycle reload the register, giving one flit per cycle.
- Latency: one cycle from fifo accept to switch_request/switch_flit valid.
- FSM states: IDLE, ROUTE, DROP.
- IDLE, on accepted HEADER or SINGLE:
  - Source mode: hop = flit[hop_width-1:0].
    - If hop < directions: request = 1<<hop.
    - Forwarded flit keeps type and tid field. The bits below the tid field are logically shifted right by hop_width, zero-filled.
  - Lookup mode: dest = flit[data-tid_width-1 -: dest_width].
    - If dest < num_dests and the entry is nonzero: request = lookup entry.
    - Flit is forwarded unchanged.
  - traffic_id <= flit[data-1 -: tid_width].
  - Next state: HEADER -> ROUTE; SINGLE -> IDLE.
  - Invalid route: no request, route_err pulses, drop_count increments (saturating). HEADER -> DROP; SINGLE is consumed only.
- IDLE, accepted PAYLOAD or LAST (orphan): consumed and discarded; route_err pulses; drop_count increments; stay IDLE.
- ROUTE: PAYLOAD/LAST forwarded unchanged with the held request. LAST -> IDLE after accept. HEADER/SINGLE received in ROUTE is forwarded as payload and not reinterpreted.
- DROP: every valid flit accepted immediately and discarded. LAST -> IDLE. No further route_err pulses.
- Once set, the request is stable while unread; it deasserts the cycle after the final read if no new flit was accepted.
- traffic_id is updated only on valid header acceptance and holds otherwise.

Decomposition:
- Shared package lisnoc_pkg: flit type constants, flit_t typedef, and mode constants ROUTE_SRC/ROUTE_LUT.
- One sub-module: lisnoc_route_decode. Combinational; header -> {one-hot request, rewritten flit, valid}. Contains both modes, selected by routing_mode.

Test Plan:
- Source mode, SINGLE with data 0x5000_0002 -> request 5'b00100, forwarded data 0x5000_0000, traffic_id 5, single-cycle latency.
- Source mode, HEADER hop 1 + 3 payload + LAST with switch_read held high -> request 5'b00010 for 5 consecutive cycles, fifo_ready high every cycle, then request 0.
- Back-pressure: switch_read low for 4 cycles mid-packet -> fifo_ready 0, switch_flit and request stable, no flit lost or duplicated.
- Invalid hop 6 with directions = 5 on HEADER + 2 payload + LAST -> no request ever; route_err single pulse; drop_count 0 -> 1; all 4 flits consumed; next valid packet routed normally.
- Lookup mode, num_dests = 4, dest 2 mapped to 5'b01000 -> request 01000 and header unchanged; dest 7 -> dropped, route_err pulses.
- Reset asserted mid-packet then released -> outputs 0 asynchronously; remaining payload/LAST treated as orphans, drop_count increments by 2.
